// File: rtl/pingpong_loop_buffer_pkg.sv
// Shared definitions for the ping-pong loop buffer: bank state encoding,
// default beat/burst geometry in bytes and pointer width helpers.
package pingpong_loop_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_t;

    localparam int DEFAULT_DATA_WIDTH = 512;
    localparam int DEFAULT_BURST_LEN  = 64;
    localparam int BEAT_BYTES         = DEFAULT_DATA_WIDTH / 8;
    localparam int BURST_BYTES        = BEAT_BYTES * DEFAULT_BURST_LEN;

    // Bytes covered by one burst for an arbitrary geometry.
    function automatic int burst_bytes(input int data_width, input int burst_len);
        return (data_width / 8) * burst_len;
    endfunction

    // Bits needed to address 0..depth-1 (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Bits needed to count 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pingpong_loop_buffer_bank_ram.sv
// One bank of beat storage: a single write port and an asynchronous read
// port so the head beat can fall through to the consumer combinationally.
module lb_bank_ram
    import pingpong_loop_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8 * BEAT_BYTES,
    parameter int DEPTH      = BURST_BYTES / BEAT_BYTES
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ptr_width(DEPTH)-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [ptr_width(DEPTH)-1:0]  raddr,
    output logic [DATA_WIDTH-1:0]        rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store a fill beat; the array has no reset since contents are only read once a bank is full.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pingpong_loop_buffer.sv
// Two-bank ping-pong input buffer: bursts are prefetched into one bank while
// the consumer drains (and optionally replays) the other one.
module pingpong_loop_buffer
    import pingpong_loop_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BURST_LEN  = DEFAULT_BURST_LEN,
    parameter int ADDR_W     = 64,
    parameter int LOOP_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_start,
    input  logic                  end_conv,
    input  logic [ADDR_W-1:0]     addr_base,
    input  logic [31:0]           num_bursts,
    input  logic [LOOP_W-1:0]     loop_cnt,
    output logic                  rmst_req,
    output logic [ADDR_W-1:0]     rmst_addr,
    input  logic                  rmst_done,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  valid,
    output logic                  ready,
    input  logic                  pop_req,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  buf_rdy,
    output logic                  done
);

    localparam int PTR_W = ptr_width(BURST_LEN);
    localparam int CNT_W = cnt_width(BURST_LEN);
    localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(BURST_LEN);
    localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(burst_bytes(DATA_WIDTH, BURST_LEN));

    bank_state_t           bank_state [2];
    logic                  wr_bank, fill_bank, rd_bank;
    logic [CNT_W-1:0]      wr_cnt, wr_cnt_next;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LOOP_W-1:0]     pass_cnt, loop_q, eff_loop;
    logic [31:0]           req_idx, pop_idx, num_bursts_q;
    logic [ADDR_W-1:0]     addr_base_q, rmst_addr_q, next_addr;
    logic                  running, outstanding, fill_done_seen, done_q;
    logic                  req_fire, fill_fire, fill_complete, pop_fire, last_beat, last_pass;
    logic [DATA_WIDTH-1:0] bank0_data, bank1_data;

    // Request/fill/pop qualifiers; a request is suppressed in a cycle whose edge clears or restarts the block.
    always_comb begin
        eff_loop      = (loop_q == '0) ? LOOP_W'(1) : loop_q;
        req_fire      = running && !rst && !end_conv && !op_start && !outstanding
                        && (bank_state[wr_bank] == EMPTY) && (req_idx < num_bursts_q);
        next_addr     = addr_base_q + ADDR_W'(req_idx) * ADDR_STRIDE;
        ready         = (bank_state[fill_bank] == FILLING) && (wr_cnt < CNT_FULL);
        fill_fire     = valid && ready;
        wr_cnt_next   = wr_cnt + CNT_W'(fill_fire);
        fill_complete = (bank_state[fill_bank] == FILLING) && (wr_cnt_next == CNT_FULL)
                        && (fill_done_seen || rmst_done);
        o_valid       = (bank_state[rd_bank] == FULL) || (bank_state[rd_bank] == READING);
        pop_fire      = pop_req && o_valid;
        last_beat     = (rd_ptr == PTR_LAST);
        last_pass     = (pass_cnt >= eff_loop - LOOP_W'(1));
        buf_rdy       = (bank_state[0] == FULL) || (bank_state[0] == READING)
                        || (bank_state[1] == FULL) || (bank_state[1] == READING);
    end

    assign rmst_req  = req_fire;
    assign rmst_addr = req_fire ? next_addr : rmst_addr_q;
    assign o_data    = rd_bank ? bank1_data : bank0_data;
    assign done      = done_q;

    // Fill FSM, read FSM, request and pass counters; fill and release touch different banks and both apply.
    always_ff @(posedge clk) begin
        if (rst || end_conv || op_start) begin
            bank_state[0]  <= EMPTY;
            bank_state[1]  <= EMPTY;
            wr_bank        <= 1'b0;
            fill_bank      <= 1'b0;
            rd_bank        <= 1'b0;
            wr_cnt         <= '0;
            rd_ptr         <= '0;
            pass_cnt       <= '0;
            req_idx        <= '0;
            pop_idx        <= '0;
            rmst_addr_q    <= '0;
            outstanding    <= 1'b0;
            fill_done_seen <= 1'b0;
            running        <= 1'b0;
            done_q         <= 1'b0;
            if (rst) begin
                addr_base_q  <= '0;
                num_bursts_q <= '0;
                loop_q       <= '0;
            end else if (!end_conv) begin
                addr_base_q  <= addr_base;
                num_bursts_q <= num_bursts;
                loop_q       <= loop_cnt;
                running      <= (num_bursts != 32'd0);
                done_q       <= (num_bursts == 32'd0);
            end
        end else begin
            done_q <= 1'b0;
            if (rmst_done) begin
                outstanding    <= 1'b0;
                fill_done_seen <= 1'b1;
            end
            if (fill_fire) begin
                wr_cnt <= wr_cnt_next;
            end
            if (fill_complete) begin
                bank_state[fill_bank] <= FULL;
            end
            if (req_fire) begin
                bank_state[wr_bank] <= FILLING;
                fill_bank           <= wr_bank;
                wr_bank             <= ~wr_bank;
                req_idx             <= req_idx + 32'd1;
                rmst_addr_q         <= next_addr;
                outstanding         <= 1'b1;
                fill_done_seen      <= 1'b0;
                wr_cnt              <= '0;
            end
            if (pop_fire) begin
                if (bank_state[rd_bank] == FULL) begin
                    bank_state[rd_bank] <= READING;
                end
                if (!last_beat) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end else begin
                    rd_ptr <= '0;
                    if (!last_pass) begin
                        pass_cnt <= pass_cnt + LOOP_W'(1);
                    end else begin
                        bank_state[rd_bank] <= EMPTY;
                        pass_cnt            <= '0;
                        rd_bank             <= ~rd_bank;
                        pop_idx             <= pop_idx + 32'd1;
                        if (pop_idx + 32'd1 == num_bursts_q) begin
                            done_q  <= 1'b1;
                            running <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    lb_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BURST_LEN)
    ) u_bank0 (
        .clk   (clk),
        .we    (fill_fire && (fill_bank == 1'b0)),
        .waddr (wr_cnt[PTR_W-1:0]),
        .wdata (tdata),
        .raddr (rd_ptr),
        .rdata (bank0_data)
    );

    lb_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BURST_LEN)
    ) u_bank1 (
        .clk   (clk),
        .we    (fill_fire && (fill_bank == 1'b1)),
        .waddr (wr_cnt[PTR_W-1:0]),
        .wdata (tdata),
        .raddr (rd_ptr),
        .rdata (bank1_data)
    );

endmodule

// File: tb/tb_pingpong_loop_buffer.sv
// Directed bench for pingpong_loop_buffer with a behavioural read master
// and a consumer that checks every popped beat against a precomputed list.
module tb_pingpong_loop_buffer;

    localparam int DW = 512;
    localparam int BL = 64;

    logic          clk = 1'b0;
    logic          rst, op_start, end_conv;
    logic [63:0]   addr_base;
    logic [31:0]   num_bursts;
    logic [7:0]    loop_cnt;
    logic          rmst_req;
    logic [63:0]   rmst_addr;
    logic          rmst_done = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic          valid = 1'b0;
    logic          ready;
    logic          pop_req = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_valid, buf_rdy, done;

    int            checkCount = 0;
    int            errorCount = 0;
    int            cyc = 0;
    int            opCyc, doneCyc;
    logic [63:0]   reqAddrQ [$];
    int            reqCycQ [$];
    logic [63:0]   rspQ [$];
    int            rspDoneCycQ [$];
    logic [DW-1:0] expQ [$];
    int            rspBurst = 0;
    int            rspBeat = 0;
    logic          rspAbort = 1'b0;
    logic          rspExtra = 1'b0;
    logic          popEnable = 1'b0;
    int            popCount = 0;
    int            lastPopCyc = -1;
    int            firstValidCyc = -1;
    int            bubbles = 0;
    int            bubbleWindow = 0;

    pingpong_loop_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .op_start   (op_start),
        .end_conv   (end_conv),
        .addr_base  (addr_base),
        .num_bursts (num_bursts),
        .loop_cnt   (loop_cnt),
        .rmst_req   (rmst_req),
        .rmst_addr  (rmst_addr),
        .rmst_done  (rmst_done),
        .tdata      (tdata),
        .valid      (valid),
        .ready      (ready),
        .pop_req    (pop_req),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .buf_rdy    (buf_rdy),
        .done       (done)
    );

    // Free-running clock and cycle counter used for latency measurements.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare one observed value with its expected value and report a mismatch.
    task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Beat contents are a pure function of the byte address they come from.
    function automatic logic [DW-1:0] beatFor(input logic [63:0] addr, input int beat);
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) begin
            v[k*32 +: 32] = addr[31:0] + 32'(beat) * 32'h40 + 32'(k) * 32'h0101_0000;
        end
        return v;
    endfunction

    function automatic logic [63:0] getReqAddr(input int i);
        if (i < reqAddrQ.size()) return reqAddrQ[i];
        return '1;
    endfunction

    function automatic int getReqCyc(input int i);
        if (i < reqCycQ.size()) return reqCycQ[i];
        return -1000;
    endfunction

    function automatic int getDoneCyc(input int i);
        if (i < rspDoneCycQ.size()) return rspDoneCycQ[i];
        return -1000;
    endfunction

    // Record every burst request, sampled just after the falling edge once inputs have settled.
    always begin
        @(negedge clk);
        #1;
        if (rmst_req === 1'b1) begin
            reqAddrQ.push_back(rmst_addr);
            reqCycQ.push_back(cyc);
            rspQ.push_back(rmst_addr);
        end
    end

    // Read master model: stream one beat per cycle for each request, then pulse rmst_done.
    always begin
        logic [63:0] addr;
        @(negedge clk);
        if (rspQ.size() > 0 && !rspAbort) begin
            addr = rspQ.pop_front();
            rspBurst++;
            rspBeat = 0;
            while (rspBeat < BL && !rspAbort) begin
                valid = 1'b1;
                tdata = beatFor(addr, rspBeat);
                if (ready === 1'b1) rspBeat++;
                @(negedge clk);
            end
            valid = 1'b0;
            if (!rspAbort) begin
                if (rspExtra) begin
                    valid = 1'b1;
                    tdata = '1;
                    checkOutput("extraBeatReady", ready, 0);
                    @(negedge clk);
                    valid = 1'b0;
                end
                rmst_done = 1'b1;
                rspDoneCycQ.push_back(cyc);
                @(negedge clk);
                rmst_done = 1'b0;
            end
        end
    end

    // Consumer: hold pop_req while enabled and check each accepted beat in order.
    always begin
        @(negedge clk);
        pop_req = popEnable;
        if (popEnable && o_valid === 1'b1) begin
            if (popCount == 0) firstValidCyc = cyc;
            if (expQ.size() > 0) checkOutput("popData", o_data, expQ.pop_front());
            popCount++;
            lastPopCyc = cyc;
        end else if (popEnable && popCount > 0 && popCount < bubbleWindow) begin
            bubbles++;
        end
    end

    // Start an operation and build the expected beat stream for it.
    task automatic applyStimulus(input logic [63:0] base, input logic [31:0] nb, input logic [7:0] lc);
        int eff;
        reqAddrQ.delete();
        reqCycQ.delete();
        rspQ.delete();
        rspDoneCycQ.delete();
        expQ.delete();
        popCount      = 0;
        bubbles       = 0;
        firstValidCyc = -1;
        lastPopCyc    = -1;
        rspBurst      = 0;
        eff = (lc == 8'd0) ? 1 : int'(lc);
        for (int b = 0; b < int'(nb); b++)
            for (int p = 0; p < eff; p++)
                for (int i = 0; i < BL; i++)
                    expQ.push_back(beatFor(base + 64'(b) * 64'h1000, i));
        addr_base  = base;
        num_bursts = nb;
        loop_cnt   = lc;
        op_start   = 1'b1;
        opCyc      = cyc;
        @(negedge clk);
        op_start   = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int   k = 0;
        logic timedOut;
        while (done !== 1'b1 && k < limit) begin
            @(negedge clk);
            k++;
        end
        timedOut = (done !== 1'b1);
        doneCyc  = cyc;
        checkOutput("doneTimeout", timedOut, 0);
    endtask

    task automatic waitRspDone(input int n, input int limit);
        int   k = 0;
        logic timedOut;
        while (rspDoneCycQ.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        timedOut = (rspDoneCycQ.size() < n);
        checkOutput("fillTimeout", timedOut, 0);
    endtask

    // Directed test sequence.
    initial begin
        int   k;
        logic timedOut;
        rst        = 1'b1;
        op_start   = 1'b0;
        end_conv   = 1'b0;
        addr_base  = '0;
        num_bursts = '0;
        loop_cnt   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstReq",    rmst_req,  0);
        checkOutput("rstAddr",   rmst_addr, 0);
        checkOutput("rstReady",  ready,     0);
        checkOutput("rstValid",  o_valid,   0);
        checkOutput("rstBufRdy", buf_rdy,   0);
        checkOutput("rstDone",   done,      0);

        $display("[TB] single burst");
        rspExtra  = 1'b1;
        popEnable = 1'b1;
        applyStimulus(64'h1000, 1, 1);
        waitDone(2000);
        checkOutput("t1ReqCount",    reqAddrQ.size(), 1);
        checkOutput("t1ReqAddr",     getReqAddr(0), 64'h1000);
        checkOutput("t1ReqLatency",  getReqCyc(0) - opCyc, 1);
        checkOutput("t1PopCount",    popCount, 64);
        checkOutput("t1FullToValid", firstValidCyc - getDoneCyc(0), 1);
        checkOutput("t1DoneLatency", doneCyc - lastPopCyc, 1);
        @(negedge clk);
        checkOutput("t1DonePulse",   done, 0);
        rspExtra = 1'b0;

        $display("[TB] ping-pong");
        popEnable = 1'b0;
        applyStimulus(64'h1000, 4, 1);
        waitRspDone(2, 1000);
        repeat (2) @(negedge clk);
        checkOutput("t2PrimedValid",  o_valid, 1);
        checkOutput("t2PrimedBufRdy", buf_rdy, 1);
        bubbleWindow = 2 * BL;
        popEnable    = 1'b1;
        waitDone(3000);
        checkOutput("t2ReqCount", reqAddrQ.size(), 4);
        checkOutput("t2ReqAddr0", getReqAddr(0), 64'h1000);
        checkOutput("t2ReqAddr1", getReqAddr(1), 64'h2000);
        checkOutput("t2ReqAddr2", getReqAddr(2), 64'h3000);
        checkOutput("t2ReqAddr3", getReqAddr(3), 64'h4000);
        checkOutput("t2PopCount", popCount, 4 * BL);
        checkOutput("t2Bubbles",  bubbles, 0);
        bubbleWindow = 0;

        $display("[TB] replay");
        applyStimulus(64'h1000, 2, 3);
        waitDone(3000);
        checkOutput("t3PopCount",   popCount, 6 * BL);
        checkOutput("t3ReqCount",   reqAddrQ.size(), 2);
        checkOutput("t3SecondReq",  getReqCyc(1) - getDoneCyc(0), 1);
        checkOutput("t3ExpLeft",    expQ.size(), 0);

        $display("[TB] end_conv during fill");
        popEnable = 1'b0;
        applyStimulus(64'h1000, 2, 1);
        k = 0;
        while (!(rspBurst == 2 && rspBeat >= 30) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        timedOut = !(rspBurst == 2 && rspBeat >= 30);
        checkOutput("t4BeatTimeout", timedOut, 0);
        checkOutput("t4ValidBefore", o_valid, 1);
        end_conv = 1'b1;
        rspAbort = 1'b1;
        @(negedge clk);
        end_conv = 1'b0;
        checkOutput("t4Ready",  ready,   0);
        checkOutput("t4Valid",  o_valid, 0);
        checkOutput("t4BufRdy", buf_rdy, 0);
        repeat (10) @(negedge clk);
        checkOutput("t4NoReq",  reqAddrQ.size(), 2);
        rspAbort  = 1'b0;
        popEnable = 1'b1;
        applyStimulus(64'h1000, 1, 1);
        waitDone(2000);
        checkOutput("t4RestartAddr", getReqAddr(0), 64'h1000);
        checkOutput("t4RestartPops", popCount, BL);

        $display("[TB] loop_cnt=0");
        applyStimulus(64'h0002_0000, 1, 0);
        waitDone(2000);
        checkOutput("t5ReqAddr",  getReqAddr(0), 64'h0002_0000);
        checkOutput("t5PopCount", popCount, BL);

        $display("[TB] num_bursts=0");
        popEnable = 1'b0;
        applyStimulus(64'h1000, 0, 1);
        checkOutput("t6DoneImmediate", done, 1);
        @(negedge clk);
        checkOutput("t6DonePulse", done, 0);
        repeat (5) @(negedge clk);
        checkOutput("t6NoReq", reqAddrQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
